branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage branch resolution unit; closes the loop back to the fetch stage.
- Consumes the fetch-time prediction (PPCCB) carried down the pipeline with each instruction and the actual branch outcome computed in execute.
- Drives the fetch-stage redirect and predictor-update interface: FlushPipeandPC, WriteEnable, CB_o, JmpAddr, JmpInstrAddr, CHJmpAddr.
- Squashes wrong-path instructions still in flight after a redirect, and keeps branch/mispredict statistics.

Parameters:
- SHADOW, 1, non-stalled cycles after a flush during which incoming valid instructions are treated as wrong-path and ignored (1..7).
- CNT_W, 32, width of the statistics counters.

Ports:
- Clk  in  1  clock; all flops rising edge.
- Rst  in  1  asynchronous reset, active-low.
- ExValid  in  1  instruction in execute is valid (PCSource carried from fetch).
- ExStall  in  1  execute stage stalled this cycle; no resolution performed.
- IsCondBr  in  1  instruction is a conditional branch.
- IsJump  in  1  instruction is an unconditional jump.
- BrTaken  in  1  conditional branch outcome; ignored unless IsCondBr.
- BrTarget  in  32  computed branch/jump target.
- InstrAddr  in  32  address of the instruction.
- PC  in  32  fall-through address (InstrAddr+4).
- PPCCB  in  34  {predicted next PC[31:0], counter bits[1:0]} from fetch.
- FlushPipeandPC  out  1  one-cycle redirect pulse to fetch.
- JmpAddr  out  32  correct next PC; valid when FlushPipeandPC=1.
- WriteEnable  out  1  one-cycle predictor update pulse.
- CB_o  out  2  new counter value for the predictor entry.
- JmpInstrAddr  out  32  predictor entry index (instruction address).
- CHJmpAddr  out  32  target written into the predictor entry.
- BranchCount  out  CNT_W  resolved branches and jumps.
- MispredCount  out  CNT_W  flushes issued.

Behaviour:
- Reset (Rst=0, asynchronous): all outputs 0, squash counter 0, statistics counters 0. Reset mid-squash clears the squash counter; the first valid instruction after release is resolved normally.
- Resolve condition:
  - res = ExValid & ~ExStall & (squash==0).
  - Latency 1: outputs are registered on the edge after the resolving cycle.
  - FlushPipeandPC and WriteEnable are single-cycle pulses. They are 0 in any cycle following a non-resolving cycle.
  - JmpAddr, CB_o, JmpInstrAddr and CHJmpAddr hold their last value when not updated.
- Actual next PC: act = (IsJump | (IsCondBr & BrTaken)) ? BrTarget : PC.
- Misprediction: mis = (act != PPCCB[33:2]).
- Conditional branch (IsCondBr=1):
  - WriteEnable=1.
  - If taken: CB_o = (CB==3) ? 3 : CB+1. If not taken: CB_o = (CB==0) ? 0 : CB-1. Saturating, never wraps.
  - CHJmpAddr=BrTarget; JmpInstrAddr=InstrAddr.
- Jump (IsJump=1, takes priority over IsCondBr):
  - WriteEnable=1, CB_o=2'b11, CHJmpAddr=BrTarget, JmpInstrAddr=InstrAddr.
- Non-branch with mis=1 (false predictor hit):
  - WriteEnable=1, CB_o=2'b00 (invalidate), CHJmpAddr=PC, JmpInstrAddr=InstrAddr.
- Non-branch with mis=0: no pulse.
- Flush:
  - If res & mis: FlushPipeandPC=1, JmpAddr=act, MispredCount+=1.
  - The squash counter loads SHADOW on the same edge the flush is registered.
- Squash:
  - While squash!=0, valid instructions are dropped: no update, no flush, no counting.
  - squash decrements by 1 on each edge where ExStall=0; it holds while ExStall=1.
- BranchCount increments on res & (IsCondBr|IsJump).
- Both statistics counters wrap modulo 2^CNT_W.
- Back-to-back: a resolving cycle immediately following a resolving cycle without flush is processed normally; pulses may stay high on consecutive cycles.

Test Plan:
1. Reset: hold Rst=0 with ExValid=1 and a mispredicting jump -> all outputs 0, counters 0; release, next resolve works normally.
2. Correctly predicted taken branch: InstrAddr=0x100, PC=0x104, BrTarget=0x200, BrTaken=1, PPCCB={0x200,2'b10} -> next cycle WriteEnable=1, CB_o=2'b11, JmpInstrAddr=0x100, CHJmpAddr=0x200, Flush=0, BranchCount=1.
3. Mispredicted not-taken branch: PPCCB={0x200,2'b00}, BrTaken=0, PC=0x104 -> CB_o=2'b00 (saturated), Flush=1, JmpAddr=0x104, MispredCount=1. The valid instruction in the following cycle is ignored (SHADOW=1).
4. Squash with stall: flush issued, then ExStall=1 for 3 cycles with ExValid=1 -> no pulses. First unstalled cycle is still squashed; the next one resolves.
5. False hit on non-branch: PPCCB={0x300,2'b01}, PC=0x108, InstrAddr=0x104 -> Flush=1, JmpAddr=0x108, WriteEnable=1, CB_o=2'b00, CHJmpAddr=0x108.
6. Counter wrap: CNT_W=2, four resolved jumps -> BranchCount sequence 1,2,3,0.

Source files
------------

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: checks the fetch-time prediction against the
// actual outcome, redirects fetch, updates the predictor and squashes wrong-path work.
module branch_resolve #(
  parameter int unsigned SHADOW = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ExValid,
  input  logic             ExStall,
  input  logic             IsCondBr,
  input  logic             IsJump,
  input  logic             BrTaken,
  input  logic [31:0]      BrTarget,
  input  logic [31:0]      InstrAddr,
  input  logic [31:0]      PC,
  input  logic [33:0]      PPCCB,
  output logic             FlushPipeandPC,
  output logic [31:0]      JmpAddr,
  output logic             WriteEnable,
  output logic [1:0]       CB_o,
  output logic [31:0]      JmpInstrAddr,
  output logic [31:0]      CHJmpAddr,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  localparam int unsigned SQ_W = 3;

  logic             flush_q, flush_d;
  logic             we_q, we_d;
  logic [1:0]       cb_q, cb_d;
  logic [31:0]      jmp_addr_q, jmp_addr_d;
  logic [31:0]      jmp_iaddr_q, jmp_iaddr_d;
  logic [31:0]      ch_addr_q, ch_addr_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [SQ_W-1:0]  squash_q, squash_d;

  logic        res;
  logic        mis;
  logic [31:0] act;
  logic [31:0] pred_pc;
  logic [1:0]  cb_in;

  // Resolution, predictor update and squash bookkeeping
  always_comb begin
    flush_d     = 1'b0;
    we_d        = 1'b0;
    cb_d        = cb_q;
    jmp_addr_d  = jmp_addr_q;
    jmp_iaddr_d = jmp_iaddr_q;
    ch_addr_d   = ch_addr_q;
    bcnt_d      = bcnt_q;
    mcnt_d      = mcnt_q;
    squash_d    = squash_q;

    pred_pc = PPCCB[33:2];
    cb_in   = PPCCB[1:0];
    act     = (IsJump | (IsCondBr & BrTaken)) ? BrTarget : PC;
    mis     = (act != pred_pc);
    res     = ExValid & ~ExStall & (squash_q == '0);

    if (!ExStall && squash_q != '0) begin
      squash_d = squash_q - SQ_W'(1);
    end

    if (res) begin
      if (IsJump) begin
        we_d        = 1'b1;
        cb_d        = 2'b11;
        ch_addr_d   = BrTarget;
        jmp_iaddr_d = InstrAddr;
      end else if (IsCondBr) begin
        we_d        = 1'b1;
        if (BrTaken) cb_d = (cb_in == 2'b11) ? 2'b11 : cb_in + 2'd1;
        else         cb_d = (cb_in == 2'b00) ? 2'b00 : cb_in - 2'd1;
        ch_addr_d   = BrTarget;
        jmp_iaddr_d = InstrAddr;
      end else if (mis) begin
        // Predictor hit on a non-branch: invalidate the entry
        we_d        = 1'b1;
        cb_d        = 2'b00;
        ch_addr_d   = PC;
        jmp_iaddr_d = InstrAddr;
      end

      if (IsJump | IsCondBr) bcnt_d = bcnt_q + CNT_W'(1);

      if (mis) begin
        flush_d    = 1'b1;
        jmp_addr_d = act;
        mcnt_d     = mcnt_q + CNT_W'(1);
        squash_d   = SQ_W'(SHADOW);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      flush_q     <= 1'b0;
      we_q        <= 1'b0;
      cb_q        <= 2'b00;
      jmp_addr_q  <= '0;
      jmp_iaddr_q <= '0;
      ch_addr_q   <= '0;
      bcnt_q      <= '0;
      mcnt_q      <= '0;
      squash_q    <= '0;
    end else begin
      flush_q     <= flush_d;
      we_q        <= we_d;
      cb_q        <= cb_d;
      jmp_addr_q  <= jmp_addr_d;
      jmp_iaddr_q <= jmp_iaddr_d;
      ch_addr_q   <= ch_addr_d;
      bcnt_q      <= bcnt_d;
      mcnt_q      <= mcnt_d;
      squash_q    <= squash_d;
    end
  end

  assign FlushPipeandPC = flush_q;
  assign JmpAddr        = jmp_addr_q;
  assign WriteEnable    = we_q;
  assign CB_o           = cb_q;
  assign JmpInstrAddr   = jmp_iaddr_q;
  assign CHJmpAddr      = ch_addr_q;
  assign BranchCount    = bcnt_q;
  assign MispredCount   = mcnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: hand-computed vectors on a 32-bit-counter
// instance and a 2-bit-counter instance driven from the same stimulus.
module tb_branch_resolve;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ExValid, ExStall, IsCondBr, IsJump, BrTaken;
  logic [31:0] BrTarget, InstrAddr, PC;
  logic [33:0] PPCCB;

  logic        flush, we;
  logic [1:0]  cb;
  logic [31:0] jmp_addr, jmp_iaddr, ch_addr, bcnt, mcnt;

  logic        w_flush, w_we;
  logic [1:0]  w_cb;
  logic [31:0] w_jmp_addr, w_jmp_iaddr, w_ch_addr;
  logic [1:0]  w_bcnt, w_mcnt;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  branch_resolve #(.SHADOW(1), .CNT_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .ExValid(ExValid), .ExStall(ExStall),
    .IsCondBr(IsCondBr), .IsJump(IsJump), .BrTaken(BrTaken),
    .BrTarget(BrTarget), .InstrAddr(InstrAddr), .PC(PC), .PPCCB(PPCCB),
    .FlushPipeandPC(flush), .JmpAddr(jmp_addr), .WriteEnable(we), .CB_o(cb),
    .JmpInstrAddr(jmp_iaddr), .CHJmpAddr(ch_addr),
    .BranchCount(bcnt), .MispredCount(mcnt)
  );

  branch_resolve #(.SHADOW(1), .CNT_W(2)) dut_w (
    .Clk(Clk), .Rst(Rst), .ExValid(ExValid), .ExStall(ExStall),
    .IsCondBr(IsCondBr), .IsJump(IsJump), .BrTaken(BrTaken),
    .BrTarget(BrTarget), .InstrAddr(InstrAddr), .PC(PC), .PPCCB(PPCCB),
    .FlushPipeandPC(w_flush), .JmpAddr(w_jmp_addr), .WriteEnable(w_we), .CB_o(w_cb),
    .JmpInstrAddr(w_jmp_iaddr), .CHJmpAddr(w_ch_addr),
    .BranchCount(w_bcnt), .MispredCount(w_mcnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic st, input logic c, input logic j,
                     input logic t, input logic [31:0] tgt, input logic [31:0] ia,
                     input logic [31:0] pc_i, input logic [31:0] pred, input logic [1:0] cbits);
    ExValid = v; ExStall = st; IsCondBr = c; IsJump = j; BrTaken = t;
    BrTarget = tgt; InstrAddr = ia; PC = pc_i; PPCCB = {pred, cbits};
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulses(input string tag, input logic exp_fl, input logic exp_we);
    check({tag, ".flush"}, 32'(flush), 32'(exp_fl));
    check({tag, ".we"}, 32'(we), 32'(exp_we));
  endtask

  initial begin
    // 1. Reset held with a valid mispredicting jump
    Rst = 1'b0;
    drv(1, 0, 0, 1, 0, 32'h500, 32'h100, 32'h104, 32'h104, 2'b00);
    step(); step();
    pulses("rst", 0, 0);
    check("rst.cb", 32'(cb), 32'h0);
    check("rst.jmp", jmp_addr, 32'h0);
    check("rst.jia", jmp_iaddr, 32'h0);
    check("rst.ch", ch_addr, 32'h0);
    check("rst.bc", bcnt, 32'h0);
    check("rst.mc", mcnt, 32'h0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    #2 Rst = 1'b1;
    step();
    pulses("idle", 0, 0);

    // 2. Correctly predicted taken branch
    drv(1, 0, 1, 0, 1, 32'h200, 32'h100, 32'h104, 32'h200, 2'b10);
    step();
    pulses("t2", 0, 1);
    check("t2.cb", 32'(cb), 32'h3);
    check("t2.jia", jmp_iaddr, 32'h100);
    check("t2.ch", ch_addr, 32'h200);
    check("t2.bc", bcnt, 32'd1);
    check("t2.mc", mcnt, 32'd0);

    // 3. Mispredicted not-taken branch, counter saturates at 0
    drv(1, 0, 1, 0, 0, 32'h200, 32'h100, 32'h104, 32'h200, 2'b00);
    step();
    pulses("t3", 1, 1);
    check("t3.cb", 32'(cb), 32'h0);
    check("t3.jmp", jmp_addr, 32'h104);
    check("t3.mc", mcnt, 32'd1);
    check("t3.bc", bcnt, 32'd2);
    drv(1, 0, 0, 1, 0, 32'h400, 32'h104, 32'h108, 32'h108, 2'b00);
    step();
    pulses("t3.shadow", 0, 0);
    check("t3.shadow.bc", bcnt, 32'd2);
    check("t3.shadow.jmp", jmp_addr, 32'h104);
    check("t3.shadow.cb", 32'(cb), 32'h0);

    // 4. Flush, then stalls hold the squash counter
    drv(1, 0, 0, 1, 0, 32'h600, 32'h110, 32'h114, 32'h114, 2'b01);
    step();
    pulses("t4", 1, 1);
    check("t4.jmp", jmp_addr, 32'h600);
    check("t4.cb", 32'(cb), 32'h3);
    check("t4.bc", bcnt, 32'd3);
    check("t4.mc", mcnt, 32'd2);
    drv(1, 1, 0, 1, 0, 32'h700, 32'h600, 32'h604, 32'h604, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      pulses("t4.stall", 0, 0);
    end
    drv(1, 0, 0, 1, 0, 32'h700, 32'h600, 32'h604, 32'h604, 2'b00);
    step();
    pulses("t4.squash", 0, 0);
    check("t4.squash.bc", bcnt, 32'd3);
    check("t4.squash.mc", mcnt, 32'd2);
    drv(1, 0, 1, 0, 1, 32'h180, 32'h120, 32'h124, 32'h180, 2'b11);
    step();
    pulses("t4.res", 0, 1);
    check("t4.res.cb", 32'(cb), 32'h3);
    check("t4.res.bc", bcnt, 32'd4);
    check("t4.res.jia", jmp_iaddr, 32'h120);
    // back-to-back resolves
    drv(1, 0, 1, 0, 1, 32'h1c0, 32'h180, 32'h184, 32'h1c0, 2'b01);
    step();
    pulses("b2b1", 0, 1);
    check("b2b1.cb", 32'(cb), 32'h2);
    drv(1, 0, 1, 0, 0, 32'h300, 32'h1c0, 32'h1c4, 32'h1c4, 2'b10);
    step();
    pulses("b2b2", 0, 1);
    check("b2b2.cb", 32'(cb), 32'h1);
    check("b2b2.bc", bcnt, 32'd6);

    // 5. False predictor hit on a non-branch
    drv(1, 0, 0, 0, 0, 32'h0, 32'h104, 32'h108, 32'h300, 2'b01);
    step();
    pulses("t5", 1, 1);
    check("t5.jmp", jmp_addr, 32'h108);
    check("t5.cb", 32'(cb), 32'h0);
    check("t5.ch", ch_addr, 32'h108);
    check("t5.jia", jmp_iaddr, 32'h104);
    check("t5.bc", bcnt, 32'd6);
    check("t5.mc", mcnt, 32'd3);
    drv(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    step();
    drv(1, 0, 0, 0, 0, 32'h0, 32'h108, 32'h10c, 32'h10c, 2'b00);
    step();
    pulses("t5.nomis", 0, 0);
    check("t5.nomis.mc", mcnt, 32'd3);

    // Reset in the middle of a squash window
    drv(1, 0, 0, 1, 0, 32'h800, 32'h200, 32'h204, 32'h204, 2'b00);
    step();
    pulses("mid", 1, 1);
    #2 Rst = 1'b0;
    #1;
    pulses("mid.rst", 0, 0);
    check("mid.rst.bc", bcnt, 32'd0);
    #2 Rst = 1'b1;

    // 6. Four resolved jumps on the 2-bit counters: 1,2,3,0
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 0, 1, 0, 32'h900 + 32'(i * 16), 32'h880 + 32'(i * 4),
          32'h884 + 32'(i * 4), 32'h900 + 32'(i * 16), 2'b11);
      step();
      check("t6.bcw", 32'(w_bcnt), 32'((i + 1) % 4));
      check("t6.we", 32'(w_we), 32'h1);
      check("t6.flush", 32'(w_flush), 32'h0);
    end
    check("t6.bc32", bcnt, 32'd4);
    check("t6.mcw", 32'(w_mcnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
